// File: rtl/regfile_write_arbiter.sv
// Arbitrates two requesters (ALU writeback, memory/IO load) onto the single write
// port of the 4x8 register bank, and exports a pending mask for hazard detection.
module regfile_write_arbiter #(
    parameter bit FAIR          = 1'b1,
    parameter bit PRIORITY_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       a_valid,
    input  logic [1:0] a_reg,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [1:0] b_reg,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       write_enable,
    output logic [1:0] write_register,
    output logic [7:0] data,
    output logic [3:0] pending,
    output logic       grant_b
);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } requester_e;

    grant_e     grant;
    requester_e prio;
    logic       contended;

    assign contended = a_valid && b_valid;

    // Ready is combinational so a lone request is accepted in the cycle it is raised.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
        grant = GRANT_NONE;
        if (!rst && !hold) begin
            if (contended) begin
                grant = (FAIR && prio == REQ_B) ? GRANT_B : GRANT_A;
            end else if (a_valid) begin
                grant = GRANT_A;
            end else if (b_valid) begin
                grant = GRANT_B;
            end
        end
    end

    assign a_ready = (grant == GRANT_A);
    assign b_ready = (grant == GRANT_B);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            write_enable   <= 1'b0;
            write_register <= 2'd0;
            data           <= 8'd0;
            grant_b        <= 1'b0;
            prio           <= requester_e'(PRIORITY_INIT);
        end else begin
            write_enable <= (grant != GRANT_NONE);
            case (grant)
                GRANT_A: begin
                    write_register <= a_reg;
                    data           <= a_data;
                    grant_b        <= 1'b0;
                end
                GRANT_B: begin
                    write_register <= b_reg;
                    data           <= b_data;
                    grant_b        <= 1'b1;
                end
                default: ;
            endcase
            // Only a contended grant moves the pointer, and it moves to the loser.
            if (FAIR && contended && grant != GRANT_NONE) begin
                prio <= (grant == GRANT_A) ? REQ_B : REQ_A;
            end
        end
    end

    // Register in flight on the bank port, plus any live request not yet written.
    always_comb begin
        pending = 4'b0000;
        if (write_enable) pending[write_register] = 1'b1;
        if (a_valid)      pending[a_reg]          = 1'b1;
        if (b_valid)      pending[b_reg]          = 1'b1;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Drives a round-robin and a fixed-priority instance from shared requesters and
// checks both against a cycle-level reference model and a register-bank model.
module tb_regfile_write_arbiter;

    logic       clk = 1'b0;
    logic       rst, hold;
    logic       a_valid, b_valid;
    logic [1:0] a_reg, b_reg;
    logic [7:0] a_data, b_data;

    // Index 0: FAIR=1 instance, index 1: FAIR=0 instance.
    logic [1:0]       a_rdy, b_rdy, wen, gb;
    logic [1:0][1:0]  wreg;
    logic [1:0][7:0]  wdata;
    logic [1:0][3:0]  pend;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit         m_we   [2];
    bit         m_gb   [2];
    bit         m_favb [2];
    logic [1:0] m_reg  [2];
    logic [7:0] m_data [2];
    logic [7:0] exp_bank [2][4] = '{default: 8'h00};
    logic [7:0] bank     [2][4] = '{default: 8'h00};
    bit         xfer_a [2];
    bit         xfer_b [2];

    always #5 clk = ~clk;

    regfile_write_arbiter #(.FAIR(1'b1), .PRIORITY_INIT(1'b0)) dut_rr (
        .clk(clk), .rst(rst), .hold(hold),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_rdy[0]),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_rdy[0]),
        .write_enable(wen[0]), .write_register(wreg[0]), .data(wdata[0]),
        .pending(pend[0]), .grant_b(gb[0])
    );

    regfile_write_arbiter #(.FAIR(1'b0), .PRIORITY_INIT(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .hold(hold),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_rdy[1]),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_rdy[1]),
        .write_enable(wen[1]), .write_register(wreg[1]), .data(wdata[1]),
        .pending(pend[1]), .grant_b(gb[1])
    );

    // Register bank: commits the registered command on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (wen[d] === 1'b1) bank[d][wreg[d]] <= wdata[d];
    end

    // One clock cycle: inputs already set at a falling edge. Checks readies, pending
    // and bank before the rising edge, the registered command after it.
    task automatic drive_cycle();
        int   win [2];
        logic [3:0] exp_pend;
        #1;
        for (int d = 0; d < 2; d++) begin
            // 0 = nobody, 1 = A, 2 = B
            win[d] = 0;
            if (!rst && !hold) begin
                if (a_valid && b_valid) win[d] = (d == 0 && m_favb[d]) ? 2 : 1;
                else if (a_valid)       win[d] = 1;
                else if (b_valid)       win[d] = 2;
            end
            n_cmp++;
            if (a_rdy[d] !== 1'(win[d] == 1)) begin
                n_err++; $display("FAIL a_ready dut%0d t=%0t: got %b want %b", d, $time, a_rdy[d], win[d] == 1);
            end
            n_cmp++;
            if (b_rdy[d] !== 1'(win[d] == 2)) begin
                n_err++; $display("FAIL b_ready dut%0d t=%0t: got %b want %b", d, $time, b_rdy[d], win[d] == 2);
            end
            exp_pend = 4'b0000;
            if (m_we[d]) exp_pend = exp_pend | (4'b0001 << m_reg[d]);
            if (a_valid) exp_pend = exp_pend | (4'b0001 << a_reg);
            if (b_valid) exp_pend = exp_pend | (4'b0001 << b_reg);
            n_cmp++;
            if (pend[d] !== exp_pend) begin
                n_err++; $display("FAIL pending dut%0d t=%0t: got %b want %b", d, $time, pend[d], exp_pend);
            end
            for (int r = 0; r < 4; r++) begin
                n_cmp++;
                if (bank[d][r] !== exp_bank[d][r]) begin
                    n_err++; $display("FAIL bank dut%0d r%0d t=%0t: got %h want %h", d, r, $time, bank[d][r], exp_bank[d][r]);
                end
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            xfer_a[d] = (win[d] == 1);
            xfer_b[d] = (win[d] == 2);
            if (rst) begin
                m_we[d] = 0; m_gb[d] = 0; m_favb[d] = 0; m_reg[d] = 2'd0; m_data[d] = 8'h00;
            end else if (win[d] != 0) begin
                m_we[d]   = 1;
                m_gb[d]   = (win[d] == 2);
                m_reg[d]  = (win[d] == 2) ? b_reg : a_reg;
                m_data[d] = (win[d] == 2) ? b_data : a_data;
                exp_bank[d][m_reg[d]] = m_data[d];
                if (d == 0 && a_valid && b_valid) m_favb[d] = (win[d] == 1);
            end else begin
                m_we[d] = 0;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (wen[d] !== m_we[d] || wreg[d] !== m_reg[d] || wdata[d] !== m_data[d] || gb[d] !== m_gb[d]) begin
                n_err++;
                $display("FAIL command dut%0d t=%0t: got we=%b reg=%0d data=%h gb=%b want we=%b reg=%0d data=%h gb=%b",
                         d, $time, wen[d], wreg[d], wdata[d], gb[d], m_we[d], m_reg[d], m_data[d], m_gb[d]);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_reset();
        rst = 1'b1; hold = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        drive_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; a_reg = 2'd1; a_data = 8'h5A; b_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_rdy[0] !== 1'b0) begin n_err++; $display("FAIL reset_a_ready: got %b want 0", a_rdy[0]); end
        drive_cycle();
        drive_cycle();
        n_cmp++;
        if (wen[0] !== 1'b0 || wdata[0] !== 8'h00 || wreg[0] !== 2'd0 || gb[0] !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got we=%b reg=%0d data=%h gb=%b want 0/0/00/0", wen[0], wreg[0], wdata[0], gb[0]);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_rdy[0] !== 1'b1) begin n_err++; $display("FAIL release_a_ready: got %b want 1", a_rdy[0]); end
        drive_cycle();
        a_valid = 1'b0;
        drive_cycle();
    endtask

    task automatic test_single_writer();
        a_valid = 1'b1; a_reg = 2'd2; a_data = 8'hA5;
        drive_cycle();
        a_valid = 1'b0;
        #1;
        n_cmp++;
        if (wen[0] !== 1'b1 || wreg[0] !== 2'd2 || wdata[0] !== 8'hA5 || pend[0] !== 4'b0100) begin
            n_err++; $display("FAIL single_writer: got we=%b reg=%0d data=%h pend=%b want 1/2/a5/0100", wen[0], wreg[0], wdata[0], pend[0]);
        end
        n_cmp++;
        if (bank[0][2] !== 8'hA5) begin n_err++; $display("FAIL single_writer_bank: got %h want a5", bank[0][2]); end
        drive_cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq;
        idle_reset();
        a_valid = 1'b1; a_reg = 2'd1; a_data = 8'h11;
        b_valid = 1'b1; b_reg = 2'd3; b_data = 8'h33;
        for (int i = 0; i < 4; i++) begin
            drive_cycle();
            seq[i] = gb[0];
        end
        n_cmp++;
        if (seq !== 4'b1010) begin n_err++; $display("FAIL round_robin_seq: got %b want 1010 (lsb first)", seq); end
        a_valid = 1'b0; b_valid = 1'b0;
        drive_cycle();
    endtask

    task automatic test_fixed_priority();
        idle_reset();
        a_valid = 1'b1; a_reg = 2'd1; a_data = 8'h11;
        b_valid = 1'b1; b_reg = 2'd3; b_data = 8'h33;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (b_rdy[1] !== 1'b0 || a_rdy[1] !== 1'b1) begin
                n_err++; $display("FAIL fixed_contended cycle %0d: got a=%b b=%b want 1/0", i, a_rdy[1], b_rdy[1]);
            end
            drive_cycle();
        end
        a_valid = 1'b0;
        #1;
        n_cmp++;
        if (b_rdy[1] !== 1'b1) begin n_err++; $display("FAIL fixed_b_after_a_drops: got %b want 1", b_rdy[1]); end
        drive_cycle();
        n_cmp++;
        if (gb[1] !== 1'b1 || wreg[1] !== 2'd3 || wdata[1] !== 8'h33) begin
            n_err++; $display("FAIL fixed_b_write: got gb=%b reg=%0d data=%h want 1/3/33", gb[1], wreg[1], wdata[1]);
        end
        b_valid = 1'b0;
        drive_cycle();
    endtask

    task automatic test_same_register();
        idle_reset();
        a_valid = 1'b1; a_reg = 2'd0; a_data = 8'h01;
        b_valid = 1'b1; b_reg = 2'd0; b_data = 8'hFF;
        drive_cycle();
        a_valid = 1'b0;
        #1;
        n_cmp++;
        if (pend[0][0] !== 1'b1 || wdata[0] !== 8'h01) begin
            n_err++; $display("FAIL same_reg_first: got pend0=%b data=%h want 1/01", pend[0][0], wdata[0]);
        end
        drive_cycle();
        b_valid = 1'b0;
        #1;
        n_cmp++;
        if (pend[0][0] !== 1'b1 || wdata[0] !== 8'hFF) begin
            n_err++; $display("FAIL same_reg_second: got pend0=%b data=%h want 1/ff", pend[0][0], wdata[0]);
        end
        n_cmp++;
        if (bank[0][0] !== 8'hFF) begin n_err++; $display("FAIL same_reg_bank: got %h want ff", bank[0][0]); end
        drive_cycle();
    endtask

    task automatic test_hold_reset();
        idle_reset();
        a_valid = 1'b1; a_reg = 2'd1; a_data = 8'h22;
        b_valid = 1'b1; b_reg = 2'd2; b_data = 8'h44;
        hold = 1'b1;
        #1;
        n_cmp++;
        if (a_rdy !== 2'b00 || b_rdy !== 2'b00) begin
            n_err++; $display("FAIL hold_readies: got a=%b b=%b want 00/00", a_rdy, b_rdy);
        end
        drive_cycle();
        n_cmp++;
        if (wen !== 2'b00) begin n_err++; $display("FAIL hold_write_enable: got %b want 00", wen); end
        hold = 1'b0;
        drive_cycle();               // contended: A wins, B becomes favoured
        rst = 1'b1; hold = 1'b1;     // reset dominates on what would be B's grant edge
        #1;
        n_cmp++;
        if (b_rdy[0] !== 1'b0) begin n_err++; $display("FAIL reset_blocks_grant: got %b want 0", b_rdy[0]); end
        drive_cycle();
        n_cmp++;
        if (wen[0] !== 1'b0) begin n_err++; $display("FAIL reset_write_enable: got %b want 0", wen[0]); end
        rst = 1'b0; hold = 1'b0; a_valid = 1'b0;
        drive_cycle();
        n_cmp++;
        if (wen[0] !== 1'b1 || gb[0] !== 1'b1 || wreg[0] !== 2'd2 || wdata[0] !== 8'h44) begin
            n_err++; $display("FAIL b_after_reset: got we=%b gb=%b reg=%0d data=%h want 1/1/2/44", wen[0], gb[0], wreg[0], wdata[0]);
        end
        a_valid = 1'b1;              // pointer must be back at A after reset
        #1;
        n_cmp++;
        if (a_rdy[0] !== 1'b1 || b_rdy[0] !== 1'b0) begin
            n_err++; $display("FAIL prio_after_reset: got a=%b b=%b want 1/0", a_rdy[0], b_rdy[0]);
        end
        drive_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        drive_cycle();
    endtask

    // Random traffic; requesters obey the handshake of instance p.
    task automatic test_random(input int p, input int cycles);
        int  wait_a, wait_b;
        bit  was_a, was_b, was_quiet;
        wait_a = 0; wait_b = 0;
        idle_reset();
        for (int c = 0; c < cycles; c++) begin
            if (!a_valid && $urandom_range(0, 99) < 55) begin
                a_valid = 1'b1; a_reg = 2'($urandom); a_data = 8'($urandom);
            end
            if (!b_valid && $urandom_range(0, 99) < 55) begin
                b_valid = 1'b1; b_reg = 2'($urandom); b_data = 8'($urandom);
            end
            hold = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 39) == 0);
            was_a = a_valid; was_b = b_valid;
            was_quiet = !rst && !hold;
            drive_cycle();
            if (rst) begin
                wait_a = 0; wait_b = 0;
            end else if (was_quiet) begin
                wait_a = (was_a && !xfer_a[0]) ? wait_a + 1 : 0;
                wait_b = (was_b && !xfer_b[0]) ? wait_b + 1 : 0;
            end
            if (p == 0) begin
                n_cmp++;
                if (wait_a > 1 || wait_b > 1) begin
                    n_err++; $display("FAIL contention_bound t=%0t: waits a=%0d b=%0d want <=1", $time, wait_a, wait_b);
                end
            end
            if (xfer_a[p]) a_valid = 1'b0;
            if (xfer_b[p]) b_valid = 1'b0;
        end
        rst = 1'b0; hold = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        drive_cycle();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        a_valid = 1'b0; a_reg = 2'd0; a_data = 8'h00;
        b_valid = 1'b0; b_reg = 2'd0; b_data = 8'h00;
        for (int d = 0; d < 2; d++) begin
            m_we[d] = 0; m_gb[d] = 0; m_favb[d] = 0; m_reg[d] = 2'd0; m_data[d] = 8'h00;
        end
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_single_writer();
        test_round_robin();
        test_fixed_priority();
        test_same_register();
        test_hold_reset();
        test_random(0, 400);
        test_random(1, 400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
